// File: rtl/controlador_correccion.sv
// Sequencer for the SECDED correction datapath. It accepts one received word per transaction,
// classifies the syndrome, registers the corrected result and keeps saturating error statistics.
module controlador_correccion #(
   parameter int ANCHO_CONT      = 8,
   parameter bit DESCARTAR_DOBLE = 1'b0
) (
   input  logic                  reloj,
   input  logic                  reset,
   input  logic                  entrada_valida,
   input  logic [7:0]            palabra_entrada,
   output logic                  entrada_lista,
   output logic [7:0]            palabra_dp,
   input  logic                  s1,
   input  logic                  s2,
   input  logic                  s3,
   input  logic                  st,
   output logic                  error_simple_dp,
   output logic                  error_doble_dp,
   input  logic [3:0]            corregido_dp,
   input  logic [7:0]            palabra_corregida_dp,
   output logic                  salida_valida,
   input  logic                  salida_lista,
   output logic [3:0]            dato_salida,
   output logic [7:0]            palabra_salida,
   output logic                  bandera_simple,
   output logic                  bandera_doble,
   input  logic                  limpiar_cuentas,
   output logic [ANCHO_CONT-1:0] cuenta_simple,
   output logic [ANCHO_CONT-1:0] cuenta_doble,
   output logic                  led_doblerror
);

   typedef enum logic [1:0] {INACTIVO, EVALUA, CAPTURA, ENTREGA} estado_t;

   localparam logic [ANCHO_CONT-1:0] CUENTA_MAX = '1;

   estado_t    estado;
   logic [2:0] sindrome;

   assign sindrome = {s1, s2, s3};

   // Any set overall-parity check means a single (correctable) error, including the parity bit
   // itself; a nonzero syndrome with clean overall parity is an uncorrectable double error.
   always_ff @(posedge reloj) begin
      if (reset) begin
         estado          <= INACTIVO;
         entrada_lista   <= 1'b0;
         palabra_dp      <= '0;
         error_simple_dp <= 1'b0;
         error_doble_dp  <= 1'b0;
         salida_valida   <= 1'b0;
         dato_salida     <= '0;
         palabra_salida  <= '0;
         bandera_simple  <= 1'b0;
         bandera_doble   <= 1'b0;
         cuenta_simple   <= '0;
         cuenta_doble    <= '0;
         led_doblerror   <= 1'b0;
      end else begin
         case (estado)
            INACTIVO: begin
               entrada_lista <= 1'b1;
               if (entrada_lista && entrada_valida) begin
                  palabra_dp    <= palabra_entrada;
                  entrada_lista <= 1'b0;
                  estado        <= EVALUA;
               end
            end
            EVALUA: begin
               error_simple_dp <= st;
               error_doble_dp  <= (sindrome != 3'b000) && !st;
               estado          <= CAPTURA;
            end
            CAPTURA: begin
               dato_salida    <= corregido_dp;
               palabra_salida <= palabra_corregida_dp;
               bandera_simple <= error_simple_dp;
               bandera_doble  <= error_doble_dp;
               if (error_doble_dp && DESCARTAR_DOBLE) begin
                  entrada_lista <= 1'b1;
                  estado        <= INACTIVO;
               end else begin
                  salida_valida <= 1'b1;
                  estado        <= ENTREGA;
               end
            end
            ENTREGA: begin
               if (salida_lista) begin
                  salida_valida <= 1'b0;
                  entrada_lista <= 1'b1;
                  estado        <= INACTIVO;
               end
            end
            default: estado <= INACTIVO;
         endcase

         // Clearing takes priority over the increment of a word finishing capture this cycle.
         if (limpiar_cuentas) begin
            cuenta_simple <= '0;
            cuenta_doble  <= '0;
            led_doblerror <= 1'b0;
         end else if (estado == CAPTURA) begin
            if (error_simple_dp && (cuenta_simple != CUENTA_MAX))
               cuenta_simple <= cuenta_simple + 1'b1;
            if (error_doble_dp) begin
               led_doblerror <= 1'b1;
               if (cuenta_doble != CUENTA_MAX)
                  cuenta_doble <= cuenta_doble + 1'b1;
            end
         end
      end
   end

endmodule
